mem_stage_lsu: RTL and testbench

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/mem_stage_lsu.sv | 213 +++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: routes requests to the D-cache or an MMIO window,
// aligns/extends load data, tracks MMIO timeouts and owns the MEM/WB register.
//
// state | meaning
// IDLE  | no access outstanding; a new aligned request is issued combinationally
// CACHE | D-cache access waiting for dc_ready_i
// MMIO  | MMIO access waiting for mmio_ack_i or the wait-cycle timeout
// HOLD  | access finished while WB was frozen; result parked until enable_i
module mem_stage_lsu #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] MMIO_BASE    = 32'h4000_0000,
  parameter int unsigned     MMIO_WORDS   = 16,
  parameter int unsigned     MMIO_TIMEOUT = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic                          flush_i,
  input  logic                          req_valid_i,
  input  logic                          req_we_i,
  input  logic [1:0]                    req_size_i,
  input  logic                          req_unsigned_i,
  input  logic [XLEN-1:0]               addr_i,
  input  logic [XLEN-1:0]               wdata_i,
  input  logic [XLEN-1:0]               alu_i,
  input  logic [XLEN-1:0]               pc4_i,
  input  logic [XLEN-1:0]               inst_i,
  input  logic [4:0]                    rd_i,
  input  logic                          regwen_i,
  input  logic [1:0]                    wbsel_i,
  output logic                          dc_valid_o,
  output logic                          dc_we_o,
  output logic [XLEN-1:0]               dc_addr_o,
  output logic [XLEN-1:0]               dc_wdata_o,
  output logic [XLEN/8-1:0]             dc_be_o,
  input  logic                          dc_ready_i,
  input  logic [XLEN-1:0]               dc_rdata_i,
  output logic                          mmio_cs_o,
  output logic                          mmio_we_o,
  output logic [$clog2(MMIO_WORDS)-1:0] mmio_addr_o,
  output logic [XLEN-1:0]               mmio_wdata_o,
  input  logic                          mmio_ack_i,
  input  logic [XLEN-1:0]               mmio_rdata_i,
  output logic                          stall_o,
  output logic [XLEN-1:0]               alu_wb_o,
  output logic [XLEN-1:0]               pc4_wb_o,
  output logic [XLEN-1:0]               inst_wb_o,
  output logic [4:0]                    rd_wb_o,
  output logic                          regwen_wb_o,
  output logic [1:0]                    wbsel_wb_o,
  output logic [XLEN-1:0]               mem_wb_o,
  output logic                          err_wb_o
);
  localparam int unsigned AW = $clog2(MMIO_WORDS);
  localparam int unsigned BW = XLEN / 8;
  localparam int unsigned CW = $clog2(MMIO_TIMEOUT + 1);
  localparam logic [XLEN:0] MMIO_LO = {1'b0, MMIO_BASE};
  localparam logic [XLEN:0] MMIO_HI = MMIO_LO + (XLEN+1)'(4 * MMIO_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_CACHE, S_MMIO, S_HOLD} state_t;

  state_t          r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [XLEN-1:0] r_hold_data;
  logic            r_hold_err;
  logic            r_kill;

  logic            w_is_mmio, w_mis, w_req, w_to, w_done, w_err;
  logic [XLEN-1:0] w_word, w_shift, w_ext, w_load;
  logic [BW-1:0]   w_be;
  logic [XLEN-1:0] w_wdata;

  assign w_is_mmio = ({1'b0, addr_i} >= MMIO_LO) && ({1'b0, addr_i} < MMIO_HI);
  assign w_mis     = req_valid_i && (((req_size_i == 2'd1) && addr_i[0]) ||
                                     ((req_size_i[1]) && (addr_i[1:0] != 2'b00)));
  assign w_req     = req_valid_i && !w_mis;
  assign w_to      = (r_state == S_MMIO) && (r_cnt == CW'(MMIO_TIMEOUT));
  assign w_err     = w_mis || w_to;

  always_comb begin
    w_done = 1'b0;
    case (r_state)
      S_IDLE:  w_done = w_req && (w_is_mmio ? mmio_ack_i : dc_ready_i);
      S_CACHE: w_done = dc_ready_i;
      S_MMIO:  w_done = mmio_ack_i || w_to;
      S_HOLD:  w_done = 1'b1;
      default: w_done = 1'b0;
    endcase
  end

  // Bus controls come straight from the MEM inputs: the stall freezes them while waiting.
  assign dc_valid_o   = !rst_i && w_req && !w_is_mmio &&
                        ((r_state == S_IDLE) || (r_state == S_CACHE));
  assign mmio_cs_o    = !rst_i && w_req && w_is_mmio &&
                        ((r_state == S_IDLE) || ((r_state == S_MMIO) && !w_to));
  assign stall_o      = !rst_i && w_req && !w_done && (r_state != S_HOLD);
  assign dc_we_o      = dc_valid_o && req_we_i;
  assign mmio_we_o    = mmio_cs_o && req_we_i;
  assign dc_addr_o    = {addr_i[XLEN-1:2], 2'b00};
  assign mmio_addr_o  = addr_i[AW+1:2];
  assign mmio_wdata_o = wdata_i;
  assign dc_be_o      = w_be;
  assign dc_wdata_o   = w_wdata;

  always_comb begin
    w_be    = '1;
    w_wdata = wdata_i;
    case (req_size_i)
      2'd0: begin
        w_be    = BW'(1) << addr_i[1:0];
        w_wdata = {BW{wdata_i[7:0]}};
      end
      2'd1: begin
        w_be    = BW'(3) << addr_i[1:0];
        w_wdata = {(BW/2){wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_word  = w_is_mmio ? mmio_rdata_i : dc_rdata_i;
  assign w_shift = w_word >> {addr_i[1:0], 3'b000};

  always_comb begin
    w_ext = w_shift;
    case (req_size_i)
      2'd0: w_ext = {{(XLEN-8){!req_unsigned_i && w_shift[7]}}, w_shift[7:0]};
      2'd1: w_ext = {{(XLEN-16){!req_unsigned_i && w_shift[15]}}, w_shift[15:0]};
      default: ;
    endcase
  end

  assign w_load = w_to ? '0 : w_ext;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        if (w_req) begin
          if (w_done)         w_state_n = enable_i ? S_IDLE : S_HOLD;
          else if (w_is_mmio) w_state_n = S_MMIO;
          else                w_state_n = S_CACHE;
        end
      end
      S_CACHE: if (w_done) w_state_n = enable_i ? S_IDLE : S_HOLD;
      S_MMIO: begin
        if (w_done) w_state_n = enable_i ? S_IDLE : S_HOLD;
        else        w_cnt_n   = r_cnt + CW'(1);
      end
      S_HOLD:  if (enable_i) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hold_data <= '0;
      r_hold_err  <= 1'b0;
      r_kill      <= 1'b0;
      alu_wb_o    <= '0;
      pc4_wb_o    <= '0;
      inst_wb_o   <= '0;
      rd_wb_o     <= '0;
      regwen_wb_o <= 1'b0;
      wbsel_wb_o  <= '0;
      mem_wb_o    <= '0;
      err_wb_o    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      if ((r_state != S_HOLD) && w_req && w_done && !enable_i) begin
        r_hold_data <= w_load;
        r_hold_err  <= w_to;
      end
      // A flush seen while the access is still owed must survive until its result retires.
      if (flush_i && (stall_o || (r_state == S_HOLD)) && !(enable_i && !stall_o))
        r_kill <= 1'b1;
      else if (enable_i && !stall_o)
        r_kill <= 1'b0;
      if (enable_i) begin
        if (flush_i || r_kill || stall_o) begin
          alu_wb_o    <= '0;
          pc4_wb_o    <= '0;
          inst_wb_o   <= '0;
          rd_wb_o     <= '0;
          regwen_wb_o <= 1'b0;
          wbsel_wb_o  <= '0;
          mem_wb_o    <= '0;
          err_wb_o    <= 1'b0;
        end else begin
          alu_wb_o    <= alu_i;
          pc4_wb_o    <= pc4_i;
          inst_wb_o   <= inst_i;
          rd_wb_o     <= rd_i;
          wbsel_wb_o  <= wbsel_i;
          if (r_state == S_HOLD) begin
            mem_wb_o    <= r_hold_data;
            err_wb_o    <= r_hold_err;
            regwen_wb_o <= regwen_i && !r_hold_err;
          end else begin
            mem_wb_o    <= w_load;
            err_wb_o    <= w_err;
            regwen_wb_o <= regwen_i && !w_err;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: cache/MMIO loads and stores, alignment,
// timeout, HOLD, flush and reset behaviour against hand-computed values.
module tb_mem_stage_lsu;
  logic        clk_i = 1'b0;
  logic        rst_i, enable_i, flush_i, req_valid_i, req_we_i, req_unsigned_i;
  logic [1:0]  req_size_i, wbsel_i;
  logic [31:0] addr_i, wdata_i, alu_i, pc4_i, inst_i;
  logic [4:0]  rd_i;
  logic        regwen_i;
  logic        dc_valid_o, dc_we_o, dc_ready_i;
  logic [31:0] dc_addr_o, dc_wdata_o, dc_rdata_i;
  logic [3:0]  dc_be_o;
  logic        mmio_cs_o, mmio_we_o, mmio_ack_i;
  logic [3:0]  mmio_addr_o;
  logic [31:0] mmio_wdata_o, mmio_rdata_i;
  logic        stall_o;
  logic [31:0] alu_wb_o, pc4_wb_o, inst_wb_o, mem_wb_o;
  logic [4:0]  rd_wb_o;
  logic        regwen_wb_o, err_wb_o;
  logic [1:0]  wbsel_wb_o;

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;
  int n;

  always #5 clk_i = ~clk_i;

  mem_stage_lsu dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .alu_i(alu_i), .pc4_i(pc4_i), .inst_i(inst_i), .rd_i(rd_i),
    .regwen_i(regwen_i), .wbsel_i(wbsel_i),
    .dc_valid_o(dc_valid_o), .dc_we_o(dc_we_o), .dc_addr_o(dc_addr_o),
    .dc_wdata_o(dc_wdata_o), .dc_be_o(dc_be_o), .dc_ready_i(dc_ready_i),
    .dc_rdata_i(dc_rdata_i), .mmio_cs_o(mmio_cs_o), .mmio_we_o(mmio_we_o),
    .mmio_addr_o(mmio_addr_o), .mmio_wdata_o(mmio_wdata_o),
    .mmio_ack_i(mmio_ack_i), .mmio_rdata_i(mmio_rdata_i), .stall_o(stall_o),
    .alu_wb_o(alu_wb_o), .pc4_wb_o(pc4_wb_o), .inst_wb_o(inst_wb_o),
    .rd_wb_o(rd_wb_o), .regwen_wb_o(regwen_wb_o), .wbsel_wb_o(wbsel_wb_o),
    .mem_wb_o(mem_wb_o), .err_wb_o(err_wb_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  always @(negedge clk_i) begin
    if (!done) begin
      total++;
      assert (!(dc_valid_o && mmio_cs_o)) else begin
        bad++;
        $error("FAIL bus_exclusive observed dc_valid=%0b mmio_cs=%0b expected not both", dc_valid_o, mmio_cs_o);
      end
    end
  end

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    req_valid_i = 1'b1; req_we_i = 1'b0; addr_i = a; req_size_i = sz; req_unsigned_i = uns;
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b1; flush_i = 1'b0;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2; req_unsigned_i = 1'b0;
    addr_i = 32'h100; wdata_i = '0; alu_i = 32'h1234; pc4_i = 32'h8; inst_i = 32'h13;
    rd_i = 5'd3; regwen_i = 1'b1; wbsel_i = 2'd1;
    dc_ready_i = 1'b0; dc_rdata_i = '0; mmio_ack_i = 1'b0; mmio_rdata_i = '0;

    // reset holds bus and stall low and clears WB
    settle();
    chk("rst_stall", stall_o, 0);
    chk("rst_dc_valid", dc_valid_o, 0);
    step(); step();
    chk("rst_alu_wb", alu_wb_o, 0);
    chk("rst_mem_wb", mem_wb_o, 0);
    chk("rst_regwen_wb", regwen_wb_o, 0);

    // zero-stall word load
    rst_i = 1'b0; rd_i = 5'd5; alu_i = 32'h100;
    load(32'h100, 2'd2, 1'b0); dc_ready_i = 1'b1; dc_rdata_i = 32'h8081_8283;
    settle();
    chk("word_stall", stall_o, 0);
    chk("word_dc_valid", dc_valid_o, 1);
    chk("word_dc_addr", dc_addr_o, 32'h100);
    step();
    chk("word_mem_wb", mem_wb_o, 32'h8081_8283);
    chk("word_rd_wb", rd_wb_o, 5);
    chk("word_regwen_wb", regwen_wb_o, 1);
    chk("word_err_wb", err_wb_o, 0);

    // signed byte load, ready after 3 stall cycles
    load(32'h103, 2'd0, 1'b0); dc_ready_i = 1'b0; dc_rdata_i = 32'h80FF_FFFF;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("lb_stall", stall_o, 1);
      chk("lb_dc_valid", dc_valid_o, 1);
      chk("lb_dc_addr", dc_addr_o, 32'h100);
      step();
    end
    dc_ready_i = 1'b1;
    settle();
    chk("lb_done_stall", stall_o, 0);
    step();
    chk("lb_mem_wb", mem_wb_o, 32'hFFFF_FF80);

    load(32'h103, 2'd0, 1'b1);
    step();
    chk("lbu_mem_wb", mem_wb_o, 32'h0000_0080);
    load(32'h102, 2'd1, 1'b0);
    step();
    chk("lh_mem_wb", mem_wb_o, 32'hFFFF_80FF);

    // stores: lane replication and byte enables
    req_we_i = 1'b1; req_size_i = 2'd1; addr_i = 32'h202; wdata_i = 32'h1234_ABCD;
    settle();
    chk("sh_be", dc_be_o, 4'b1100);
    chk("sh_wdata", dc_wdata_o, 32'hABCD_ABCD);
    chk("sh_we", dc_we_o, 1);
    step();
    req_size_i = 2'd0; addr_i = 32'h201; wdata_i = 32'h0000_00EF;
    settle();
    chk("sb_be", dc_be_o, 4'b0010);
    chk("sb_wdata", dc_wdata_o, 32'hEFEF_EFEF);
    step();
    req_size_i = 2'd2; addr_i = 32'h204; wdata_i = 32'h5566_7788;
    settle();
    chk("sw_be", dc_be_o, 4'b1111);
    step();

    // misaligned word load
    load(32'h102, 2'd2, 1'b0); dc_ready_i = 1'b0;
    settle();
    chk("mis_dc_valid", dc_valid_o, 0);
    chk("mis_stall", stall_o, 0);
    step();
    chk("mis_err_wb", err_wb_o, 1);
    chk("mis_regwen_wb", regwen_wb_o, 0);

    // MMIO timeout
    load(32'h4000_0008, 2'd2, 1'b0);
    settle();
    chk("mmio_addr", mmio_addr_o, 2);
    chk("mmio_cs", mmio_cs_o, 1);
    chk("mmio_no_dc", dc_valid_o, 0);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (!stall_o) break;
      n++;
      step();
    end
    chk("mmio_stall_cycles", n, 256);
    chk("mmio_to_cs", mmio_cs_o, 0);
    step();
    chk("mmio_to_err_wb", err_wb_o, 1);
    chk("mmio_to_mem_wb", mem_wb_o, 0);

    // MMIO window upper edge, then first address past it
    load(32'h4000_003C, 2'd2, 1'b0); mmio_ack_i = 1'b1; mmio_rdata_i = 32'h1234_5678;
    settle();
    chk("mmio_last_addr", mmio_addr_o, 15);
    chk("mmio_last_stall", stall_o, 0);
    step();
    chk("mmio_last_mem_wb", mem_wb_o, 32'h1234_5678);
    mmio_ack_i = 1'b0;
    load(32'h4000_0040, 2'd2, 1'b0); dc_ready_i = 1'b1; dc_rdata_i = 32'h0BAD_BEEF;
    settle();
    chk("past_win_dc_valid", dc_valid_o, 1);
    chk("past_win_cs", mmio_cs_o, 0);
    step();
    chk("past_win_mem_wb", mem_wb_o, 32'h0BAD_BEEF);

    // completion while WB frozen -> HOLD, single bus cycle
    load(32'h300, 2'd2, 1'b0); enable_i = 1'b0; dc_rdata_i = 32'hCAFE_F00D;
    settle();
    chk("hold_issue_valid", dc_valid_o, 1);
    step();
    dc_ready_i = 1'b0;
    settle();
    chk("hold_no_reissue", dc_valid_o, 0);
    chk("hold_stall", stall_o, 0);
    step();
    chk("hold_wb_frozen", mem_wb_o, 32'h0BAD_BEEF);
    enable_i = 1'b1; dc_rdata_i = 32'h0;
    settle();
    chk("hold_release_valid", dc_valid_o, 0);
    step();
    chk("hold_mem_wb", mem_wb_o, 32'hCAFE_F00D);

    // flush during a cache wait: request kept, result discarded
    load(32'h400, 2'd2, 1'b0); rd_i = 5'd7; dc_rdata_i = 32'h1111_1111;
    step();
    flush_i = 1'b1;
    settle();
    chk("flush_stall", stall_o, 1);
    chk("flush_dc_valid", dc_valid_o, 1);
    step();
    flush_i = 1'b0; dc_ready_i = 1'b1;
    settle();
    chk("flush_done_stall", stall_o, 0);
    step();
    chk("flush_mem_wb", mem_wb_o, 0);
    chk("flush_rd_wb", rd_wb_o, 0);
    chk("flush_regwen_wb", regwen_wb_o, 0);

    // flush beats same-cycle load data
    flush_i = 1'b1; dc_rdata_i = 32'h2222_2222;
    step();
    chk("flush_prio_mem_wb", mem_wb_o, 0);
    flush_i = 1'b0; dc_ready_i = 1'b0;

    // enable gates the WB register
    req_valid_i = 1'b0; alu_i = 32'hDEAD; enable_i = 1'b0;
    step();
    chk("en0_alu_wb", alu_wb_o, 0);
    enable_i = 1'b1;
    step();
    chk("en1_alu_wb", alu_wb_o, 32'hDEAD);

    // reset abandons an in-flight MMIO access
    load(32'h4000_0000, 2'd2, 1'b0);
    step(); step();
    rst_i = 1'b1;
    settle();
    chk("rst_mid_cs", mmio_cs_o, 0);
    chk("rst_mid_stall", stall_o, 0);
    step();
    rst_i = 1'b0; req_valid_i = 1'b0;
    settle();
    chk("rst_mid_alu_wb", alu_wb_o, 0);
    chk("rst_mid_cs_after", mmio_cs_o, 0);

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
